// File: rtl/uctl_evt_pkg.sv
// Shared types and sizing helpers for the USB event arbiter.
package uctl_evt_pkg;

  localparam int NUM_EVT_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uctl_evt_arbiter_if.sv
// Valid/ready event port between the event arbiter and the controller core.
interface uctl_evt_arbiter_if
  import uctl_evt_pkg::*;
#(
  parameter int NUM_EVT = NUM_EVT_DEFAULT
);

  localparam int IdW = id_width(NUM_EVT);

  logic           evtValid;
  logic [IdW-1:0] evtId;
  logic           evtReady;

  modport master (output evtValid, output evtId, input evtReady);
  modport slave  (input evtValid, input evtId, output evtReady);

endinterface

// File: rtl/uctl_evt_edge_stage.sv
// One event line: optional two-flop synchronizer, previous-level register and
// masked rising-edge detect.
module uctl_evt_edge_stage #(
  parameter bit BYPASS = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic evt_i,
  input  logic mask_i,
  output logic edge_o
);

  logic sync_out;
  logic prev_q;

  generate
    if (BYPASS) begin : g_bypass
      assign sync_out = evt_i;
    end else begin : g_sync
      logic meta_q;
      logic sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= evt_i;
          sync_q <= meta_q;
        end
      end
      assign sync_out = sync_q;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sync_out;
  end

  assign edge_o = sync_out & ~prev_q & mask_i;

endmodule

// File: rtl/uctl_evt_arbiter.sv
// Latches per-line event edges and presents them one at a time, round robin.
// Optional macro UCTL_EVT_OVERFLOW_EN builds the sticky per-line overflow flags.
module uctl_evt_arbiter
  import uctl_evt_pkg::*;
#(
  parameter int NUM_EVT = NUM_EVT_DEFAULT,
  parameter bit BYPASS  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evtIn,
  input  logic [NUM_EVT-1:0] evtMask,
  input  logic               ovfClr,
  output logic [NUM_EVT-1:0] evtOvf,
  uctl_evt_arbiter_if.master evt_if
);

  // state | meaning
  // IDLE  | bubble cycle; pick the next pending line from rr_q
  // GRANT | event presented, evtId frozen until evtReady
  localparam int IdW = id_width(NUM_EVT);
  localparam logic [IdW-1:0] LastId = IdW'(NUM_EVT - 1);

  logic [NUM_EVT-1:0] edge_w;
  logic [NUM_EVT-1:0] pend_q, pend_d;
  logic [NUM_EVT-1:0] clr_mask;
  arb_state_e         state_q, state_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [IdW-1:0]     rr_q, rr_d;
  logic [IdW-1:0]     win_id;
  logic               win_found;
  logic               accept;

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_line
    uctl_evt_edge_stage #(.BYPASS(BYPASS)) u_edge (
      .clk    (clk),
      .reset  (reset),
      .evt_i  (evtIn[g]),
      .mask_i (evtMask[g]),
      .edge_o (edge_w[g])
    );
  end

  function automatic logic [IdW-1:0] rr_index(input logic [IdW-1:0] base, input int ofs);
    int k;
    k = int'(base) + ofs;
    if (k >= NUM_EVT) k = k - NUM_EVT;
    return IdW'(k);
  endfunction

  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    for (int j = 0; j < NUM_EVT; j++) begin
      if (!win_found && pend_q[rr_index(rr_q, j)]) begin
        win_id    = rr_index(rr_q, j);
        win_found = 1'b1;
      end
    end
  end

  assign accept = (state_q == ST_GRANT) && evt_if.evtReady;

  // A fresh edge on the line being accepted re-arms it instead of being lost.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[id_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | edge_w;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          id_d    = win_id;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (evt_if.evtReady) begin
          rr_d    = (id_q == LastId) ? '0 : id_q + IdW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      pend_q  <= pend_d;
    end
  end

  assign evt_if.evtValid = (state_q == ST_GRANT);
  assign evt_if.evtId    = id_q;

`ifdef UCTL_EVT_OVERFLOW_EN
  logic [NUM_EVT-1:0] ovf_q, ovf_d;

  // A new overflow beats a simultaneous clear.
  always_comb begin
    ovf_d = (ovfClr ? '0 : ovf_q) | (edge_w & pend_q & ~clr_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign evtOvf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovfClr;
  assign evtOvf         = '0;
`endif

endmodule

// File: tb/tb_uctl_evt_arbiter.sv
// Directed plus randomized bench for uctl_evt_arbiter (NUM_EVT=4, BYPASS=0).
module tb_uctl_evt_arbiter;
  import uctl_evt_pkg::*;

  localparam int N   = 4;
  localparam int IdW = id_width(N);
`ifdef UCTL_EVT_OVERFLOW_EN
  localparam logic [N-1:0] OVF_EXP = 4'b0001;
`else
  localparam logic [N-1:0] OVF_EXP = 4'b0000;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] evtIn;
  logic [N-1:0] evtMask;
  logic         ovfClr;
  logic [N-1:0] evtOvf;

  uctl_evt_arbiter_if #(.NUM_EVT(N)) bus ();

  uctl_evt_arbiter #(.NUM_EVT(N), .BYPASS(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .evtIn   (evtIn),
    .evtMask (evtMask),
    .ovfClr  (ovfClr),
    .evtOvf  (evtOvf),
    .evt_if  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: input history as seen through two sample delays,
  // pending set per line, and the event currently on offer.
  logic [N-1:0] h1, h2, h3;
  bit           m_pend [N];
  bit           m_ovf  [N];
  bit           m_valid;
  int           m_id;
  int           m_rr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 1'b0;
        m_ovf[i]  = 1'b0;
      end
      m_valid = 1'b0;
      m_id    = 0;
      m_rr    = 0;
    end else begin : model_step
      int served;
      int pick;
      bit rise;
      served = -1;
      pick   = -1;
      if (m_valid) begin
        if (bus.evtReady) served = m_id;
      end else begin
        for (int j = 0; j < N; j++)
          if (pick < 0 && m_pend[(m_rr + j) % N]) pick = (m_rr + j) % N;
      end
`ifdef UCTL_EVT_OVERFLOW_EN
      if (ovfClr)
        for (int i = 0; i < N; i++) m_ovf[i] = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
        rise = h2[i] && !h3[i] && evtMask[i];
        if (i == served) begin
          m_pend[i] = rise;
        end else if (rise) begin
`ifdef UCTL_EVT_OVERFLOW_EN
          if (m_pend[i]) m_ovf[i] = 1'b1;
`endif
          m_pend[i] = 1'b1;
        end
      end
      if (served >= 0) begin
        m_valid = 1'b0;
        m_rr    = (served + 1) % N;
      end
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_id    = pick;
      end
      h3 = h2;
      h2 = h1;
      h1 = evtIn;
    end
  end

  task automatic check_model();
    logic [N-1:0]   ovf_exp;
    logic [IdW-1:0] id_exp;
    for (int i = 0; i < N; i++) ovf_exp[i] = m_ovf[i];
    id_exp = IdW'(m_id);
    checks++;
    assert (bus.evtValid === m_valid) else begin
      errors++;
      $error("FAIL model_valid observed=%0b expected=%0b", bus.evtValid, m_valid);
    end
    checks++;
    assert (bus.evtId === id_exp) else begin
      errors++;
      $error("FAIL model_id observed=%0d expected=%0d", bus.evtId, id_exp);
    end
    checks++;
    assert (evtOvf === ovf_exp) else begin
      errors++;
      $error("FAIL model_ovf observed=%b expected=%b", evtOvf, ovf_exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic expect_v(input string tag, input logic exp_v);
    checks++;
    assert (bus.evtValid === exp_v) else begin
      errors++;
      $error("FAIL %s evtValid observed=%0b expected=%0b", tag, bus.evtValid, exp_v);
    end
  endtask

  task automatic expect_id(input string tag, input logic [IdW-1:0] exp_id);
    checks++;
    assert (bus.evtId === exp_id) else begin
      errors++;
      $error("FAIL %s evtId observed=%0d expected=%0d", tag, bus.evtId, exp_id);
    end
  endtask

  task automatic expect_ovf(input string tag, input logic [N-1:0] exp_o);
    checks++;
    assert (evtOvf === exp_o) else begin
      errors++;
      $error("FAIL %s evtOvf observed=%b expected=%b", tag, evtOvf, exp_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int waited;
    int sel;
    logic [IdW-1:0] last_id;

    reset = 1'b0; evtIn = '0; evtMask = '1; ovfClr = 1'b0; bus.evtReady = 1'b1;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    expect_v("reset_valid", 1'b0);
    expect_id("reset_id", '0);
    expect_ovf("reset_ovf", '0);
    reset = 1'b0;
    repeat (3) cyc();

    // single event on line 2, first sampled at edge k
    evtIn[2] = 1'b1;
    cyc(); expect_v("single_k", 1'b0);
    cyc(); cyc(); expect_v("single_k2", 1'b0);
    cyc(); expect_v("single_k3", 1'b1); expect_id("single_id", 2'd2);
    cyc(); expect_v("single_k4", 1'b0);
    evtIn[2] = 1'b0;
    repeat (4) cyc();
    expect_v("single_no_repeat", 1'b0);

    // rr pointer is now 3: lines 0,1,3 together serve as 3,0,1
    evtIn = 4'b1011;
    repeat (3) cyc();
    cyc(); expect_v("rr_first", 1'b1); expect_id("rr_first_id", 2'd3);
    cyc(); expect_v("rr_gap1", 1'b0);
    cyc(); expect_v("rr_second", 1'b1); expect_id("rr_second_id", 2'd0);
    cyc(); expect_v("rr_gap2", 1'b0);
    cyc(); expect_v("rr_third", 1'b1); expect_id("rr_third_id", 2'd1);
    cyc(); expect_v("rr_done", 1'b0);
    evtIn = '0;
    repeat (4) cyc();

    // backpressure on id 1
    bus.evtReady = 1'b0;
    evtIn[1] = 1'b1;
    repeat (3) cyc();
    cyc(); expect_v("bp_present", 1'b1); expect_id("bp_present_id", 2'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(); expect_v("bp_hold", 1'b1); expect_id("bp_hold_id", 2'd1);
    end
    bus.evtReady = 1'b1;
    evtIn[1] = 1'b0;
    cyc(); expect_v("bp_done", 1'b0);
    repeat (3) cyc();

    // second edge on line 0 while still pending
    bus.evtReady = 1'b0;
    evtIn[0] = 1'b1;
    repeat (3) cyc();
    evtIn[0] = 1'b0;
    cyc(); expect_v("ovf_present", 1'b1); expect_id("ovf_present_id", 2'd0);
    repeat (2) cyc();
    evtIn[0] = 1'b1;
    repeat (4) cyc();
    expect_ovf("ovf_set", OVF_EXP);
    expect_v("ovf_still_valid", 1'b1);
    evtIn[0] = 1'b0;
    bus.evtReady = 1'b1;
    cyc(); expect_v("ovf_accept", 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(); expect_v("ovf_single_delivery", 1'b0);
    end
    expect_ovf("ovf_sticky", OVF_EXP);
    ovfClr = 1'b1;
    cyc();
    ovfClr = 1'b0;
    expect_ovf("ovf_clr", '0);

    // masked edge on line 3 is lost
    evtMask[3] = 1'b0;
    evtIn[3] = 1'b1;
    repeat (4) cyc();
    evtMask[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); expect_v("mask_drop", 1'b0);
    end
    evtIn[3] = 1'b0;
    repeat (3) cyc();

    // line 1 held high through reset yields exactly one event
    evtIn[1] = 1'b1;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cnt = 0;
    last_id = '0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.evtValid === 1'b1) begin
        cnt++;
        last_id = bus.evtId;
      end
    end
    checks++;
    assert (cnt == 1) else begin
      errors++;
      $error("FAIL rst_held_count observed=%0d expected=1", cnt);
    end
    checks++;
    assert (last_id === 2'd1) else begin
      errors++;
      $error("FAIL rst_held_id observed=%0d expected=1", last_id);
    end
    evtIn[1] = 1'b0;
    repeat (4) cyc();

    // reset while in GRANT
    bus.evtReady = 1'b0;
    evtIn[2] = 1'b1;
    waited = 0;
    while (bus.evtValid !== 1'b1 && waited < 10) begin
      cyc();
      waited++;
    end
    expect_v("grant_reached", 1'b1);
    reset = 1'b1;
    evtIn = '0;
    #1;
    expect_v("reset_in_grant", 1'b0);
    repeat (2) cyc();
    reset = 1'b0;
    bus.evtReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); expect_v("post_reset_idle", 1'b0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        sel = int'($urandom_range(0, N - 1));
        evtIn[sel[1:0]] = ~evtIn[sel[1:0]];
      end
      if ($urandom_range(0, 15) == 0)
        evtMask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      bus.evtReady = ($urandom_range(0, 2) != 0);
      ovfClr = ($urandom_range(0, 9) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uctl_evt_arbiter.md
# uctl_evt_arbiter

Collects single-bit event lines that are asynchronous to `clk` (for example PHY line-state changes, suspend/resume requests, or VBUS detect), synchronizes and edge-detects each line, and latches a pending flag per line. A round-robin scheduler then presents one pending event at a time on a valid/ready event port to the USB controller core. The block sits between the external asynchronous status pins and the core's interrupt/event logic.

## Interface
- `NUM_EVT`, 4 — number of event lines; legal range 2..16.
- `BYPASS`, 0 — 1: inputs are already synchronous and the synchronizer stages are removed; 0: each line gets a two-flop synchronizer.
- `clk` input 1 — single clock for all logic.
- `reset` input 1 — asynchronous, active-high reset.
- `evtIn` input NUM_EVT — raw event lines; a rising edge is one event.
- `evtMask` input NUM_EVT — synchronous to `clk`; 1 enables the line, 0 drops its edges.
- `evtValid` output 1 — an event is presented.
- `evtId` output $clog2(NUM_EVT) — index of the presented event.
- `evtReady` input 1 — consumer accepts the event when it is high and `evtValid` is high.
- `ovfClr` input 1 — pulse that clears all overflow flags.
- `evtOvf` output NUM_EVT — sticky flag per line: an edge arrived while that line was already pending.

## Operation
- **Per line i:**
  - `syncOut[i]` is the synchronized level.
  - `prev[i]` is `syncOut[i]` delayed by one register.
  - `edge[i] = syncOut[i] & ~prev[i] & evtMask[i]`.
  - `edge[i]` sets `pend[i]`.
- **FSM states:**
  - IDLE: `evtValid` = 0. If any `pend` is set, select the winner by round robin starting from `rrPtr`, register it in `evtId`, and go to GRANT.
  - GRANT: `evtValid` = 1 and `evtId` stays stable. When `evtReady` = 1:
    - clear `pend[evtId]`;
    - set `rrPtr = (evtId+1) mod NUM_EVT`;
    - return to IDLE.
- **Throughput:** at most one event every 2 cycles. The bubble cycle in IDLE is required.
- **Simultaneous edge and acceptance on the same line:** `pend` stays 1, a new event, and no overflow is flagged.
- **Edge on a line that is already pending and not being accepted that cycle:** `pend` stays 1 and `evtOvf[i]` is set, but only when the overflow feature is compiled in.
- **`ovfClr` and a new overflow in the same cycle:** the set wins.
- **Masking:**
  - Clearing `evtMask[i]` does not clear an existing `pend[i]`.
  - A masked edge is lost permanently. It is not deferred.
- **`rrPtr` wrap-around:** after serving index NUM_EVT-1, `rrPtr` = 0.
- **Reset values:** `evtValid` = 0, `evtId` = 0, `evtOvf` = 0, `rrPtr` = 0, `pend` = 0, synchronizer flops = 0, `prev` = 0.
  - An input that is held high through reset release therefore produces exactly one event after release.
- **Reset asserted mid-operation:** any event in GRANT or pending is discarded. No handshake completes.

## Timing
- **With BYPASS=0:** the input is first sampled high at edge k.
  - `syncOut` goes high after k+1.
  - `pend` is set at k+2.
  - GRANT is entered and `evtValid` = 1 at k+3.
- **With BYPASS=1:** `evtIn` is high before edge k.
  - `pend` is set at k.
  - `evtValid` = 1 at k+1.
- `evtValid` and `evtId` are registered outputs. They never depend combinationally on `evtReady`.
- `evtOvf` is updated on the same edge that would have set `pend`.
- Pulses on `evtIn` shorter than 2 `clk` periods may be missed when BYPASS=0. This is acceptable by design.

## Configuration
- Macro `UCTL_EVT_OVERFLOW_EN`.
  - **Defined:** the overflow detection logic and the `evtOvf` register are built, and `ovfClr` is honoured.
  - **Undefined:** no overflow logic is built, `evtOvf` is tied to 0, and `ovfClr` is ignored. Pending and arbitration behaviour is identical in both builds.

## Structure
- **Package `uctl_evt_pkg`:**
  - FSM state typedef (IDLE, GRANT);
  - default `NUM_EVT`;
  - an ID-width function wrapping `$clog2`.
- **Sub-module `uctl_evt_edge_stage`:** one instance per line, built with a generate loop. It contains:
  - the two-flop synchronizer, or a pass-through when BYPASS=1;
  - the `prev` register;
  - the masked rising-edge output.
- **Top level:** `pend`, the overflow logic, the round-robin search and the FSM.

## Test plan
- **Single event, NUM_EVT=4, BYPASS=0, `evtReady` tied high:** raise `evtIn[2]`, first sampled at edge k → `evtValid` high at k+3 with `evtId`=2, low at k+4; `pend` = 0 afterwards.
- **Round-robin wrap:** with `rrPtr`=3, edges on lines 0, 1 and 3 arrive in the same cycle, `evtReady` high → events are served in order 3, 0, 1, each `evtValid` separated by one idle cycle.
- **Backpressure:** with `evtReady` low for 10 cycles, event id 1 is presented → `evtValid` and `evtId`=1 stay stable for all 10 cycles; the transfer completes on the first `evtReady` = 1.
- **Overflow, with `UCTL_EVT_OVERFLOW_EN`:** a second edge arrives on line 0 while `pend[0]` is set and not yet accepted → `evtOvf`=4'b0001 and only one event is delivered; an `ovfClr` pulse → `evtOvf`=0. Without the macro → `evtOvf` stays 0.
- **Reset and masking:**
  - Hold `evtIn[1]` high through `reset` → exactly one id-1 event after release.
  - `evtMask[3]`=0 during an edge on line 3 → no event is ever produced for it.
  - `reset` asserted while in GRANT → `evtValid` goes to 0 immediately and stays 0 after release.
